// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues fetches for the PC unit under a credit limit,
// pairs in-order memory responses with their PCs and buffers them for decode.
module if_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t         state;
  logic [CW-1:0]  occupancy;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop_cnt;
  logic [CW-1:0]  credits;
  logic [CW-1:0]  in_flight;
  logic [CW-1:0]  flush_drop;
  logic [PW-1:0]  buf_wr;
  logic [PW-1:0]  buf_rd;
  logic [PW-1:0]  pend_wr;
  logic [PW-1:0]  pend_rd;
  logic [31:0]    buf_instr [DEPTH];
  logic [31:0]    buf_pc    [DEPTH];
  logic [31:0]    pend_pc   [DEPTH];
  logic           accept;
  logic           rsp_write;
  logic           pop;

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; valid never depends on ready, and payload is held while valid waits.
  assign misaligned     = pc_in[1:0] != 2'b00;
  assign credits        = outstanding + occupancy;
  assign imem_req_valid = rst_n && (state == RUN) && !flush &&
                          (credits < CW'(DEPTH)) && !misaligned;
  assign imem_addr      = pc_in;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_advance     = accept;

  assign rsp_write   = imem_rsp_valid && (state == RUN) && (outstanding != '0);
  assign instr_valid = rst_n && (occupancy != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = buf_instr[buf_rd];
  assign instr_pc    = buf_pc[buf_rd];

  // Only one of outstanding/drop_cnt is non-zero, so their sum is what the
  // memory still owes us; a response landing on the flush cycle is already paid.
  assign in_flight  = outstanding + drop_cnt;
  assign flush_drop = in_flight - CW'(imem_rsp_valid && (in_flight != '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      occupancy   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      pend_wr     <= '0;
      pend_rd     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= 32'h0000_0013;
        buf_pc[i]    <= '0;
        pend_pc[i]   <= '0;
      end
    end else if (flush) begin
      occupancy   <= '0;
      outstanding <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      pend_wr     <= '0;
      pend_rd     <= '0;
      drop_cnt    <= flush_drop;
      state       <= (flush_drop != '0) ? DRAIN : RUN;
    end else begin
      if (accept) begin
        pend_pc[pend_wr] <= pc_in;
        pend_wr          <= pend_wr + 1'b1;
      end
      if (rsp_write) begin
        buf_instr[buf_wr] <= imem_rsp_data;
        buf_pc[buf_wr]    <= pend_pc[pend_rd];
        buf_wr            <= buf_wr + 1'b1;
        pend_rd           <= pend_rd + 1'b1;
      end
      if (pop) begin
        buf_rd <= buf_rd + 1'b1;
      end
      occupancy   <= occupancy + CW'(rsp_write) - CW'(pop);
      outstanding <= outstanding + CW'(accept) - CW'(rsp_write);
      if (state == DRAIN) begin
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
        if ((drop_cnt == '0) || (imem_rsp_valid && (drop_cnt == CW'(1)))) begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: queue-level reference model checked every
// cycle, plus literal expectations for the stream, backpressure, flush and reset cases.
module tb_if_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_in          (pc_in),
    .pc_advance     (pc_advance),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misaligned     (misaligned)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          lat   = 1;
  bit          auto_pc = 1'b0;
  int          adv_count = 0;
  int          vld_count = 0;
  int          n_wait;
  mreq_t       mem_q[$];
  logic [31:0] pend_q[$];
  logic [63:0] exp_q[$];
  int          m_drop = 0;
  bit          m_drain = 1'b0;
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_data_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1300_0000 ^ a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are compared with the
  // reference model, then model and memory advance across the posedge.
  task automatic tick();
    logic        e_mis, e_req, e_adv, e_vld, rsp, was_drain;
    logic [31:0] rsp_word;
    logic [63:0] head;
    int          credits, inflight;
    mreq_t       m;
    rsp      = 1'b0;
    rsp_word = 32'h0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due == cyc) begin
        rsp      = 1'b1;
        rsp_word = mem_word(mem_q[0].addr);
      end
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp_word;
    #1;
    e_mis   = pc_in[1:0] != 2'b00;
    credits = pend_q.size() + exp_q.size();
    e_req   = rst_n && !m_drain && !flush && (credits < DEPTH) && !e_mis;
    e_adv   = e_req && imem_req_ready;
    e_vld   = rst_n && (exp_q.size() != 0);
    check("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
    check("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
    check("pc_advance", {31'b0, pc_advance}, {31'b0, e_adv});
    check("imem_addr", imem_addr, pc_in);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, e_vld});
    if (e_vld) begin
      head = exp_q[0];
      check("instr", instr, head[63:32]);
      check("instr_pc", instr_pc, head[31:0]);
    end
    if (pc_advance === 1'b1) adv_count++;
    if (instr_valid === 1'b1) vld_count++;
    if (e_vld && instr_ready && !flush) begin
      pop_pc_log.push_back(instr_pc);
      pop_data_log.push_back(instr);
    end
    was_drain = m_drain;
    if (!rst_n) begin
      pend_q.delete();
      exp_q.delete();
      m_drop  = 0;
      m_drain = 1'b0;
    end else if (flush) begin
      inflight = m_drain ? m_drop : pend_q.size();
      if (rsp && inflight > 0) inflight--;
      pend_q.delete();
      exp_q.delete();
      m_drop  = inflight;
      m_drain = inflight > 0;
    end else begin
      if (was_drain) begin
        if (rsp && m_drop > 0) m_drop--;
        if (m_drop == 0) m_drain = 1'b0;
      end
      if (e_vld && instr_ready) void'(exp_q.pop_front());
      if (!was_drain && rsp && pend_q.size() > 0) exp_q.push_back({rsp_word, pend_q.pop_front()});
      if (e_adv) pend_q.push_back(pc_in);
    end
    if (rsp) void'(mem_q.pop_front());
    if (e_adv) begin
      m.due  = cyc + lat;
      m.addr = pc_in;
      mem_q.push_back(m);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (e_adv && auto_pc) pc_in = pc_in + 32'd4;
  endtask

  task automatic quiesce();
    int k;
    k = 0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    flush          = 1'b0;
    while ((pend_q.size() > 0 || exp_q.size() > 0 || m_drain || mem_q.size() > 0) && k < 60) begin
      tick();
      k++;
    end
    tick();
    n_vec++;
    if (k >= 60) begin
      n_err++;
      $display("FAIL quiesce_timeout: got %0d cycles required < 60", k);
    end
  endtask

  task automatic wait_req();
    n_wait = 0;
    #1;
    while (imem_req_valid !== 1'b1 && n_wait < 20) begin
      tick();
      n_wait++;
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; pc_in = 32'h0; instr_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset
    tick();
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_pc_advance", {31'b0, pc_advance}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    rst_n = 1'b1; imem_req_ready = 1'b0;
    #1;
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Stream, latency 1
    lat = 1; auto_pc = 1'b1; pc_in = 32'h0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    adv_count = 0; pop_pc_log.delete(); pop_data_log.delete();
    repeat (9) tick();
    check("stream_accepts", adv_count, 6);
    quiesce();
    check("stream_pops", pop_pc_log.size(), 6);
    if (pop_pc_log.size() >= 3) begin
      check("stream_pc0", pop_pc_log[0], 32'h0);
      check("stream_pc1", pop_pc_log[1], 32'h4);
      check("stream_pc2", pop_pc_log[2], 32'h8);
      check("stream_data0", pop_data_log[0], 32'h1300_0000);
      check("stream_data2", pop_data_log[2], 32'h1300_0008);
    end

    // Backpressure
    pc_in = 32'h40; instr_ready = 1'b0; imem_req_ready = 1'b1;
    adv_count = 0; pop_pc_log.delete(); pop_data_log.delete();
    repeat (6) tick();
    check("bp_accepts", adv_count, 2);
    #1;
    check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("bp_pc_advance", {31'b0, pc_advance}, 32'd0);
    instr_ready = 1'b1; adv_count = 0;
    repeat (6) tick();
    check("bp_resume_accepts", adv_count, 4);
    quiesce();
    if (pop_pc_log.size() >= 2) begin
      check("bp_pc0", pop_pc_log[0], 32'h40);
      check("bp_pc1", pop_pc_log[1], 32'h44);
    end else begin
      check("bp_pops", pop_pc_log.size(), 2);
    end

    // Flush with two outstanding, latency 3
    lat = 3; pc_in = 32'h80; imem_req_ready = 1'b1; instr_ready = 1'b1;
    tick();
    tick();
    flush = 1'b1; pc_in = 32'h100; vld_count = 0; pop_pc_log.delete(); pop_data_log.delete();
    tick();
    flush = 1'b0;
    wait_req();
    check("flush_wait", n_wait, 2);
    check("flush_no_valid", vld_count, 0);
    repeat (6) tick();
    quiesce();
    if (pop_pc_log.size() >= 1) begin
      check("flush_first_pc", pop_pc_log[0], 32'h100);
      check("flush_first_data", pop_data_log[0], 32'h1300_0100);
    end else begin
      check("flush_pops", pop_pc_log.size(), 1);
    end

    // Flush colliding with a response, latency 2
    lat = 2; pc_in = 32'h180; imem_req_ready = 1'b1;
    tick();
    tick();
    flush = 1'b1; pc_in = 32'h1C0; vld_count = 0; pop_pc_log.delete(); pop_data_log.delete();
    tick();
    flush = 1'b0;
    wait_req();
    check("flush_rsp_wait", n_wait, 1);
    check("flush_rsp_no_valid", vld_count, 0);
    repeat (4) tick();
    quiesce();
    if (pop_pc_log.size() >= 1) check("flush_rsp_first_pc", pop_pc_log[0], 32'h1C0);
    else check("flush_rsp_pops", pop_pc_log.size(), 1);

    // Misaligned PC, recovered by a redirect
    lat = 1; auto_pc = 1'b0; pc_in = 32'h102; imem_req_ready = 1'b1; adv_count = 0;
    repeat (3) tick();
    #1;
    check("mis_flag", {31'b0, misaligned}, 32'd1);
    check("mis_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("mis_accepts", adv_count, 0);
    flush = 1'b1; pc_in = 32'h200;
    tick();
    flush = 1'b0;
    #1;
    check("mis_resume_req", {31'b0, imem_req_valid}, 32'd1);
    check("mis_resume_adv", {31'b0, pc_advance}, 32'd1);
    auto_pc = 1'b1; pop_pc_log.delete(); pop_data_log.delete();
    repeat (4) tick();
    quiesce();
    if (pop_pc_log.size() >= 1) check("mis_first_pc", pop_pc_log[0], 32'h200);
    else check("mis_pops", pop_pc_log.size(), 1);

    // Reset with one buffered and one outstanding, latency 3
    lat = 3; pc_in = 32'h300; instr_ready = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("post_rst_instr", instr, 32'h0000_0013);
    check("post_rst_instr_pc", instr_pc, 32'h0);
    tick();
    #1;
    check("stray_ignored", {31'b0, instr_valid}, 32'd0);
    quiesce();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
